// File: rtl/booth_prod_acc.sv
// Saturating multiply-accumulate back end for the 4x4 Booth multiplier.
// Sums FRAME_LEN signed products per frame and hands each result over through a valid/ready port.
module booth_prod_acc #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 12,
    parameter int FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] Z_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sat_flag
);

    localparam int CNT_W = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [ACC_W-1:0]   accOut_q, accOut_d;
    logic               outValid_q, outValid_d;
    logic               satFlag_q, satFlag_d;

    logic [ACC_W:0]     accExt;
    logic [ACC_W:0]     prodExt;
    logic [ACC_W:0]     sumFull;
    logic               overflow;
    logic [ACC_W-1:0]   sumClamped;
    logic               accept;
    logic               lastBeat;

    // One guard bit is enough: the two top bits of the sum disagree exactly when the sum leaves the ACC_W range.
    assign accExt     = {acc_q[ACC_W-1], acc_q};
    assign prodExt    = {{(ACC_W + 1 - PROD_W){Z_in[PROD_W-1]}}, Z_in};
    assign sumFull    = accExt + prodExt;
    assign overflow   = sumFull[ACC_W] ^ sumFull[ACC_W-1];
    assign sumClamped = overflow ? (sumFull[ACC_W] ? ACC_MIN : ACC_MAX) : sumFull[ACC_W-1:0];

    assign in_ready = (state_q == ACC) && !clear;
    assign accept   = in_valid && in_ready;
    assign lastBeat = (cnt_q == LAST_CNT);

    assign acc_out   = accOut_q;
    assign out_valid = outValid_q;
    assign sat_flag  = satFlag_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        accOut_d   = accOut_q;
        outValid_d = outValid_q;
        satFlag_d  = satFlag_q;

        if (clear) begin
            state_d    = ACC;
            acc_d      = '0;
            cnt_d      = '0;
            sat_d      = 1'b0;
            outValid_d = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        if (lastBeat) begin
                            accOut_d   = sumClamped;
                            satFlag_d  = sat_q | overflow;
                            outValid_d = 1'b1;
                            state_d    = HOLD;
                            acc_d      = '0;
                            cnt_d      = '0;
                            sat_d      = 1'b0;
                        end else begin
                            acc_d = sumClamped;
                            cnt_d = cnt_q + CNT_W'(1);
                            sat_d = sat_q | overflow;
                        end
                    end
                end
                HOLD: begin
                    if (outValid_q && out_ready) begin
                        outValid_d = 1'b0;
                        state_d    = ACC;
                    end
                end
                default: begin
                    state_d = ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            accOut_q   <= '0;
            outValid_q <= 1'b0;
            satFlag_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            accOut_q   <= accOut_d;
            outValid_q <= outValid_d;
            satFlag_q  <= satFlag_d;
        end
    end

endmodule

// File: tb/tb_booth_prod_acc.sv
// Bench for booth_prod_acc: a default 12-bit instance and an 8-bit instance share stimulus,
// table frames are checked directly and every result is also scoreboarded against a clamp model.
module tb_booth_prod_acc;

    logic       clk;
    logic       rst_n;
    logic [7:0] zIn;
    logic       inValid;
    logic       clear;
    logic       outReady;

    logic        inReady12, outValid12, satFlag12;
    logic [11:0] accOut12;
    logic        inReady8, outValid8, satFlag8;
    logic [7:0]  accOut8;

    booth_prod_acc dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .Z_in      (zIn),
        .in_valid  (inValid),
        .in_ready  (inReady12),
        .clear     (clear),
        .acc_out   (accOut12),
        .out_valid (outValid12),
        .out_ready (outReady),
        .sat_flag  (satFlag12)
    );

    booth_prod_acc #(.PROD_W(8), .ACC_W(8), .FRAME_LEN(4)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .Z_in      (zIn),
        .in_valid  (inValid),
        .in_ready  (inReady8),
        .clear     (clear),
        .acc_out   (accOut8),
        .out_valid (outValid8),
        .out_ready (outReady),
        .sat_flag  (satFlag8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int acc8;
        bit sat8;
        int acc12;
        bit sat12;
    } result_t;

    result_t sbQ[$];

    int mAcc8, mAcc12, mCnt;
    bit mSat8, mSat12, mHold;

    typedef struct {
        int z [4];
        int acc8;
        bit sat8;
        int acc12;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int clampW(input int w, input int s);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    task automatic modelReset();
        mAcc8  = 0;
        mAcc12 = 0;
        mCnt   = 0;
        mSat8  = 1'b0;
        mSat12 = 1'b0;
        mHold  = 1'b0;
    endtask

    task automatic modelAccept(input int z);
        int s8, s12, c8, c12;
        result_t r;
        s8  = mAcc8 + z;
        s12 = mAcc12 + z;
        c8  = clampW(8, s8);
        c12 = clampW(12, s12);
        if (c8 != s8) mSat8 = 1'b1;
        if (c12 != s12) mSat12 = 1'b1;
        if (mCnt == 3) begin
            r.acc8  = c8;
            r.sat8  = mSat8;
            r.acc12 = c12;
            r.sat12 = mSat12;
            sbQ.push_back(r);
            mAcc8  = 0;
            mAcc12 = 0;
            mSat8  = 1'b0;
            mSat12 = 1'b0;
            mCnt   = 0;
            mHold  = 1'b1;
        end else begin
            mAcc8  = c8;
            mAcc12 = c12;
            mCnt++;
        end
    endtask

    // Drives one cycle at the falling edge and advances the model across the following rising edge.
    task automatic applyStimulus(input bit v, input logic [7:0] z, input bit clr, input bit rdy);
        bit expReady;
        @(negedge clk);
        inValid  = v;
        zIn      = z;
        clear    = clr;
        outReady = rdy;
        #1;
        expReady = !mHold && !clr;
        checkOutput("in_ready8", int'(inReady8), int'(expReady));
        checkOutput("in_ready12", int'(inReady12), int'(expReady));
        if (clr) begin
            mAcc8  = 0;
            mAcc12 = 0;
            mCnt   = 0;
            mSat8  = 1'b0;
            mSat12 = 1'b0;
            mHold  = 1'b0;
        end else if (mHold) begin
            if (rdy) mHold = 1'b0;
        end else if (v) begin
            modelAccept(int'($signed(z)));
        end
    endtask

    // Idles one cycle right after the last beat; the result must already be visible then.
    task automatic waitResult(input string name, input int e8, input bit s8, input int e12, input bit rdy);
        applyStimulus(1'b0, 8'h00, 1'b0, rdy);
        checkOutput({name, " out_valid8"}, int'(outValid8), 1);
        checkOutput({name, " out_valid12"}, int'(outValid12), 1);
        checkOutput({name, " acc8"}, int'($signed(accOut8)), e8);
        checkOutput({name, " sat8"}, int'(satFlag8), int'(s8));
        checkOutput({name, " acc12"}, int'($signed(accOut12)), e12);
        checkOutput({name, " sat12"}, int'(satFlag12), 0);
    endtask

    task automatic setVec(input int i, input int a, input int b, input int c, input int d,
                          input int e8, input bit s8, input int e12);
        vecs[i].z[0] = a;
        vecs[i].z[1] = b;
        vecs[i].z[2] = c;
        vecs[i].z[3] = d;
        vecs[i].acc8  = e8;
        vecs[i].sat8  = s8;
        vecs[i].acc12 = e12;
    endtask

    // Scoreboard: each rising out_valid must match the oldest predicted frame result.
    bit prevValid = 1'b0;
    always @(negedge clk) begin
        result_t r;
        if (outValid8 && !prevValid) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb unexpected result", 1, 0);
            end else begin
                r = sbQ.pop_front();
                checkOutput("sb acc8", int'($signed(accOut8)), r.acc8);
                checkOutput("sb sat8", int'(satFlag8), int'(r.sat8));
                checkOutput("sb acc12", int'($signed(accOut12)), r.acc12);
                checkOutput("sb sat12", int'(satFlag12), int'(r.sat12));
                checkOutput("sb out_valid12", int'(outValid12), 1);
            end
        end
        prevValid = outValid8;
    end

    initial begin
        int sparseV [7];
        int sparseZ [7];

        setVec(0, -35, 20, -16, 49, 18, 1'b0, 18);
        setVec(1, 64, 64, 64, -10, 117, 1'b1, 182);
        setVec(2, 1, 1, 1, 1, 4, 1'b0, 4);
        setVec(3, -128, -128, -128, 127, -1, 1'b1, -257);
        setVec(4, 100, -100, 100, -100, 0, 1'b0, 0);
        setVec(5, 127, 127, 127, 127, 127, 1'b1, 508);
        setVec(6, -1, -1, -1, -1, -4, 1'b0, -4);
        setVec(7, 5, 5, 5, 5, 20, 1'b0, 20);

        sparseV = '{1, 0, 0, 1, 0, 1, 1};
        sparseZ = '{-56, 0, 0, 64, 0, -1, 7};

        modelReset();
        rst_n    = 1'b0;
        inValid  = 1'b0;
        zIn      = 8'h00;
        clear    = 1'b0;
        outReady = 1'b1;
        #12;
        checkOutput("reset acc8", int'(accOut8), 0);
        checkOutput("reset acc12", int'(accOut12), 0);
        checkOutput("reset out_valid", int'(outValid8), 0);
        checkOutput("reset sat", int'(satFlag8), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                applyStimulus(1'b1, 8'(vecs[i].z[j]), 1'b0, 1'b1);
            end
            waitResult($sformatf("vec%0d", i), vecs[i].acc8, vecs[i].sat8, vecs[i].acc12, 1'b1);
        end

        // Backpressure: offered beats while holding must not be counted.
        applyStimulus(1'b1, 8'hDD, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd20, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd49, 1'b0, 1'b0);
        waitResult("bp frame", 18, 1'b0, 18, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
            checkOutput("bp held valid", int'(outValid8), 1);
            checkOutput("bp held acc", int'($signed(accOut12)), 18);
        end
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
        checkOutput("bp valid dropped", int'(outValid8), 0);
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
        waitResult("bp next", 4, 1'b0, 4, 1'b1);

        // Clear mid-frame drops the partial sum and the beat offered with it.
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd5, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'd5, 1'b0, 1'b1);
        waitResult("clear mid", 20, 1'b0, 20, 1'b1);

        // Clear while holding a result.
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b0);
        waitResult("clear hold frame", 10, 1'b0, 10, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clear hold valid", int'(outValid8), 0);
        checkOutput("clear hold acc", int'($signed(accOut8)), 10);

        for (int k = 0; k < 7; k++) begin
            applyStimulus(sparseV[k] != 0, sparseV[k] != 0 ? 8'(sparseZ[k]) : 8'($urandom), 1'b0, 1'b1);
        end
        waitResult("sparse", 14, 1'b0, 14, 1'b1);

        // Reset between edges in the middle of a frame.
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        inValid = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkOutput("midreset acc", int'(accOut8), 0);
        checkOutput("midreset acc12", int'(accOut12), 0);
        checkOutput("midreset valid", int'(outValid8), 0);
        checkOutput("midreset sat", int'(satFlag8), 0);
        modelReset();
        sbQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'd2, 1'b0, 1'b1);
        waitResult("after reset", 8, 1'b0, 8, 1'b1);

        for (int k = 0; k < 200; k++) begin
            applyStimulus($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 19) == 0,
                          $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("scoreboard drained", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
